// File: rtl/clmul_seq_if.sv
// clmul_seq_if: handshake bundle for the sequential carry-less multiplier.
//   W          operand width in bits
//   in_valid   producer -> block : operand pair a/b valid
//   in_ready   block -> producer : block accepts operands
//   a, b       producer -> block : multiplicand / multiplier (W bits)
//   out_valid  block -> consumer : product valid
//   out_ready  consumer -> block : consumer accepts product
//   product    block -> consumer : carry-less product (2W bits)
//   busy       block -> anyone   : operation in flight or result pending
// Modports: master = producer/consumer side, slave = multiplier side.
interface clmul_seq_if #(
    parameter int unsigned W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/clmul_seq.sv
// clmul_seq: iterative GF(2) (carry-less) multiplier, one multiplier bit per
// cycle, valid/ready handshakes on input and output.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - clmul_seq_if.slave: in_valid/in_ready/a/b in, out_valid/out_ready/
//          product out, busy
// Parameters:
//   W    - operand width (>= 2); product is 2W bits, product[2W-1] always 0
// Optional feature macro:
//   CLMUL_SEQ_EARLY_EXIT_EN - end RUN as soon as the remaining multiplier
//   bits are all zero (latency max(1, msb(b)+1) instead of W).
module clmul_seq #(
    parameter int unsigned W = 4
) (
    input  logic        clk,
    input  logic        rst,
    clmul_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplr;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_product;

    logic [2*W-1:0]   w_acc_nxt;
    logic [W-1:0]     w_mplr_shr;
    logic             w_last;

    // This iteration's accumulator includes the partial product selected by
    // the current multiplier LSB; the final iteration stores it directly.
    assign w_acc_nxt  = r_acc ^ ({(2*W){r_mplr[0]}} & r_mcand);
    assign w_mplr_shr = r_mplr >> 1;

`ifdef CLMUL_SEQ_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations XOR nothing.
    assign w_last = (r_cnt == CW'(W - 1)) || (w_mplr_shr == '0);
`else
    assign w_last = (r_cnt == CW'(W - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)       w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand <= {{W{1'b0}}, bus.a};
                        r_mplr  <= bus.b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= w_mplr_shr;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs depend on the state register only
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.product   = r_product;

endmodule

// File: doc/clmul_seq.md
# clmul_seq

Sequential, parametrised carry-less (GF(2)) multiplier: two W-bit operands in, one 2W-bit XOR-accumulated product out. This is the iterative successor to our fixed 4-bit combinational partial-product XOR blocks. It trades latency for area by processing one multiplier bit per cycle behind valid/ready handshakes on both sides. It sits in the bit-vector arithmetic test set as a reference for sequential equivalence against the combinational form.

## Interface
- W, 4, operand width in bits (W >= 2)
- CW, $clog2(W+1), width of iteration counter (derived localparam, not overridable)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair a/b valid
- in_ready  out  1  block accepts operands (high only in IDLE)
- a  in  W  multiplicand
- b  in  W  multiplier
- out_valid  out  1  product valid (high only in DONE)
- out_ready  in  1  consumer accepts product
- product  out  2W  carry-less product, registered
- busy  out  1  high in RUN or DONE

## Operation
- Result: product[k] = XOR over all i+j=k of (a[i] & b[j]), for k in 0..2W-2; product[2W-1] is always 0.
- Datapath registers:
  - mcand[2W-1:0]: zero-extended a.
  - mplr[W-1:0]: b.
  - acc[2W-1:0].
  - cnt[CW-1:0].
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: mcand<={0,a}, mplr<=b, acc<=0, cnt<=0, go to RUN.
- RUN, one iteration per cycle:
  - If mplr[0]=1, acc <= acc ^ mcand.
  - mcand<=mcand<<1, mplr<=mplr>>1, cnt<=cnt+1.
  - When cnt==W-1 (last iteration), go to DONE. The product register loads the final acc value, including this cycle's XOR.
- DONE:
  - out_valid=1, product held stable.
  - On out_valid & out_ready, go to IDLE; product keeps its value, out_valid drops.
- No overlap: in_ready=0 in RUN and DONE. in_valid there is ignored; a/b changes there have no effect.
- in_ready, out_valid and busy are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- Reset values: state=IDLE, in_ready=1 after the reset edge, out_valid=0, busy=0, product=0, acc/mcand/mplr/cnt=0.
- Reset mid-operation (RUN or DONE): the pending result is discarded and the block returns to IDLE on the next edge. No out_valid pulse occurs.
- rst has priority over every handshake in the same cycle.

## Timing
- Operands accepted at edge T0. RUN occupies edges T0+1..T0+L. out_valid is high from just after edge T0+L.
- Without early exit: L = W exactly.
- With early exit (see Configuration): L = max(1, p+1), where p is the index of the highest set bit of b.
- out_ready may already be high when DONE is entered. The transfer then completes at the first DONE edge, so out_valid is high for exactly 1 cycle.
- Minimum operand-to-operand spacing is L+2 cycles: accept edge, L RUN edges, 1 DONE edge. in_ready returns high in the cycle after the output transfer.
- out_ready held low: the block stays in DONE indefinitely, with product and out_valid stable.

## Configuration
- CLMUL_SEQ_EARLY_EXIT_EN
  - Defined: in RUN, if the shifted multiplier value (mplr>>1) is 0 at the end of an iteration, go to DONE immediately, regardless of cnt. The result is identical because the remaining iterations would XOR nothing. b=0 gives L=1.
  - Undefined: fixed latency L=W for every operand pair; cnt alone ends RUN.

## Test plan
- W=4, a=4'hB, b=4'h6 -> product=8'h3A. out_valid rises 4 cycles after acceptance (macro off), or 3 cycles after (macro on).
- W=4, a=4'hF, b=4'hF -> product=8'h55; product[7]=0. Back-to-back requests with in_valid held high: in_ready is low through RUN/DONE and the second pair is accepted only after the output transfer.
- W=4, a=4'h9, b=4'h0 -> product=8'h00. L=1 with macro on, L=4 with macro off.
- Backpressure: a=4'h3, b=4'h5 -> product=8'h0F. Hold out_ready=0 for 5 cycles: out_valid stays 1, product stays 8'h0F, in_ready stays 0. Raise out_ready: transfer happens in 1 cycle, then in_ready=1.
- Reset mid-RUN: accept a=4'hF, b=4'hF, assert rst on the 2nd RUN cycle -> next cycle state=IDLE, out_valid=0, product=0, in_ready=1, no stale output later.
- W=8: a=8'h80, b=8'h80 -> product=16'h4000 (L=8). a=8'hFF, b=8'h01 -> product=16'h00FF (L=1 with macro on).
  - Random sweep of 1000 pairs against a bitwise XOR-sum model; zero mismatches.
